// File: rtl/line_period_monitor_mc_pkg.sv
// Shared types and default timing constants for the multi-channel line period monitor.
// Contents: per-channel FSM state type, 48 MHz default period window / timeout,
// and the accumulator width helper.
package line_period_monitor_mc_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } ch_state_e;

  localparam int unsigned DEF_N_CH       = 2;
  localparam int unsigned DEF_CNT_WIDTH  = 16;
  localparam int unsigned DEF_PERIOD_MIN = 1440;   // 30 us at 48 MHz
  localparam int unsigned DEF_PERIOD_MAX = 5760;   // 120 us at 48 MHz
  localparam int unsigned DEF_AVG_LOG2   = 2;
  localparam int unsigned DEF_TIMEOUT    = 11520;  // 2 * PERIOD_MAX

  // Accumulator must hold up to 2^avg_log2 full-scale samples.
  function automatic int unsigned acc_width(input int unsigned cnt_width,
                                            input int unsigned avg_log2);
    return cnt_width + avg_log2;
  endfunction

endpackage

// File: rtl/line_period_ch.sv
// Single camera channel: measures LINE_END-to-LINE_END period, validates it against
// a min/max window, optionally averages 2^AVG_LOG2 accepted lines, holds the result.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   frame_start         frame-start pulse (discards the partial line)
//   line_end            line-end pulse (sampling edge)
//   pixel_error         taints the current line
//   avg_en              1 = averaged output, 0 = last accepted period
//   err_clr             clears the sticky out_of_range flag
//   line_period         held period output
//   period_valid        channel tracking with a valid period
//   out_of_range        sticky rejected-sample flag
module line_period_ch
  import line_period_monitor_mc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned PERIOD_MIN = DEF_PERIOD_MIN,
  parameter int unsigned PERIOD_MAX = DEF_PERIOD_MAX,
  parameter int unsigned AVG_LOG2   = DEF_AVG_LOG2,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 line_end,
  input  logic                 pixel_error,
  input  logic                 avg_en,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] line_period,
  output logic                 period_valid,
  output logic                 out_of_range
);

  localparam int unsigned ACC_W = acc_width(CNT_WIDTH, AVG_LOG2);
  localparam int unsigned NUM_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [NUM_W-1:0]     NUM_LAST = NUM_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_WIDTH-1:0] P_MIN    = CNT_WIDTH'(PERIOD_MIN);
  localparam logic [CNT_WIDTH-1:0] P_MAX    = CNT_WIDTH'(PERIOD_MAX);
  localparam logic [CNT_WIDTH-1:0] P_TMO    = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT  = {CNT_WIDTH{1'b1}};

  ch_state_e            state_q,    state_d;
  logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
  logic                 taint_q,    taint_d;
  logic [ACC_W-1:0]     acc_q,      acc_d;
  logic [NUM_W-1:0]     num_q,      num_d;
  logic                 avg_prev_q, avg_prev_d;
  logic [CNT_WIDTH-1:0] period_q,   period_d;
  logic                 valid_q,    valid_d;
  logic                 oor_q,      oor_d;

  logic [ACC_W-1:0]     acc_base;
  logic [NUM_W-1:0]     num_base;
  logic [ACC_W-1:0]     sum;
  logic                 accept;
  logic                 oor_set;

  // Next-state: FSM, period counter, window check, averaging and output holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    taint_d    = taint_q;
    avg_prev_d = avg_en;
    period_d   = period_q;
    valid_d    = valid_q;
    accept     = 1'b0;
    oor_set    = 1'b0;

    // A mode change restarts averaging; the held output is untouched.
    acc_base = (avg_en != avg_prev_q) ? '0 : acc_q;
    num_base = (avg_en != avg_prev_q) ? '0 : num_q;
    acc_d    = acc_base;
    num_d    = num_base;
    sum      = acc_base + ACC_W'(cnt_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        taint_d = 1'b0;
        // First edge only arms the counter; FRAME_START alone keeps waiting.
        if (line_end) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
        end
      end

      ST_MEASURE: begin
        if (frame_start) begin
          // Frame start wins over a coincident LINE_END: restart without sampling.
          cnt_d   = CNT_ONE;
          acc_d   = '0;
          num_d   = '0;
          taint_d = 1'b0;
        end else if (line_end) begin
          cnt_d   = CNT_ONE;
          taint_d = 1'b0;
          // A coincident pixel error still belongs to the line being closed.
          accept  = (cnt_q >= P_MIN) && (cnt_q <= P_MAX) && !taint_q && !pixel_error;
          if (!accept) begin
            oor_set = 1'b1;
          end else if (!avg_en) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
          end else if (num_base == NUM_LAST) begin
            period_d = CNT_WIDTH'(sum >> AVG_LOG2);
            valid_d  = 1'b1;
            acc_d    = '0;
            num_d    = '0;
          end else begin
            acc_d = sum;
            num_d = num_base + NUM_W'(1);
          end
        end else if (cnt_q >= P_TMO) begin
          // Line lost: drop validity but keep the last period for the config TX.
          state_d = ST_IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          acc_d   = '0;
          num_d   = '0;
          taint_d = 1'b0;
        end else begin
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (pixel_error) begin
            taint_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Set has priority over a same-cycle clear.
    oor_d = oor_set | (oor_q & ~err_clr);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      taint_q    <= 1'b0;
      acc_q      <= '0;
      num_q      <= '0;
      avg_prev_q <= 1'b0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      taint_q    <= taint_d;
      acc_q      <= acc_d;
      num_q      <= num_d;
      avg_prev_q <= avg_prev_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      oor_q      <= oor_d;
    end
  end

  assign line_period  = period_q;
  assign period_valid = valid_q;
  assign out_of_range = oor_q;

endmodule

// File: rtl/line_period_monitor_mc.sv
// Multi-channel line period monitor: N_CH independent line_period_ch instances.
// Ports:
//   CLOCK, RESET    system clock, synchronous active-low reset
//   FRAME_START     per-channel frame-start pulses
//   LINE_END        per-channel line-end pulses
//   PIXEL_ERROR     per-channel pixel error pulses
//   AVG_EN          shared averaging mode select
//   ERR_CLR         shared clear of all OUT_OF_RANGE bits
//   LINE_PERIOD     channel k at [k*CNT_WIDTH +: CNT_WIDTH]
//   PERIOD_VALID    per-channel valid
//   OUT_OF_RANGE    per-channel sticky rejection flag
module line_period_monitor_mc
  import line_period_monitor_mc_pkg::*;
#(
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned PERIOD_MIN = DEF_PERIOD_MIN,
  parameter int unsigned PERIOD_MAX = DEF_PERIOD_MAX,
  parameter int unsigned AVG_LOG2   = DEF_AVG_LOG2,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [N_CH-1:0]           FRAME_START,
  input  logic [N_CH-1:0]           LINE_END,
  input  logic [N_CH-1:0]           PIXEL_ERROR,
  input  logic                      AVG_EN,
  input  logic                      ERR_CLR,
  output logic [N_CH*CNT_WIDTH-1:0] LINE_PERIOD,
  output logic [N_CH-1:0]           PERIOD_VALID,
  output logic [N_CH-1:0]           OUT_OF_RANGE
);

  // One channel per slice; only AVG_EN and ERR_CLR are shared.
  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    line_period_ch #(
      .CNT_WIDTH (CNT_WIDTH),
      .PERIOD_MIN(PERIOD_MIN),
      .PERIOD_MAX(PERIOD_MAX),
      .AVG_LOG2  (AVG_LOG2),
      .TIMEOUT   (TIMEOUT)
    ) u_ch (
      .clk         (CLOCK),
      .rst_n       (RESET),
      .frame_start (FRAME_START[k]),
      .line_end    (LINE_END[k]),
      .pixel_error (PIXEL_ERROR[k]),
      .avg_en      (AVG_EN),
      .err_clr     (ERR_CLR),
      .line_period (LINE_PERIOD[k*CNT_WIDTH +: CNT_WIDTH]),
      .period_valid(PERIOD_VALID[k]),
      .out_of_range(OUT_OF_RANGE[k])
    );
  end

endmodule

// File: doc/line_period_monitor_mc.md
Name: line_period_monitor_mc

Overview:
- Multi-channel successor to the single-sensor line-period calculator.
- Measures the LINE_END-to-LINE_END period of N_CH camera channels in CLOCK cycles.
- Validates each period against a min/max window and optionally averages over 2^AVG_LOG2 lines.
- Presents a held, per-channel LINE_PERIOD to the config transmitters.
- Sits in the system clock domain; all per-channel strobes arrive already synchronised to CLOCK as 1-cycle pulses.

Parameters:
- N_CH, 2: number of sensor channels.
- CNT_WIDTH, 16: period counter and output width per channel.
- PERIOD_MIN, 1440: minimum accepted period in cycles (30 us at 48 MHz).
- PERIOD_MAX, 5760: maximum accepted period in cycles (120 us at 48 MHz).
- AVG_LOG2, 2: averaging depth exponent; 2^AVG_LOG2 accepted lines per average.
- TIMEOUT, 11520: cycles without LINE_END before a channel is declared lost (2*PERIOD_MAX).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-low reset.
- FRAME_START  in  N_CH  per-channel frame-start pulse.
- LINE_END  in  N_CH  per-channel line-end pulse.
- PIXEL_ERROR  in  N_CH  per-channel pixel error pulse; taints the current line.
- AVG_EN  in  1  mode select: 1 = averaged output, 0 = last accepted period.
- ERR_CLR  in  1  clears all OUT_OF_RANGE bits.
- LINE_PERIOD  out  N_CH*CNT_WIDTH  channel k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
- PERIOD_VALID  out  N_CH  channel currently tracking with a valid period.
- OUT_OF_RANGE  out  N_CH  sticky flag: a rejected sample was seen.

Behaviour:
- One clock; reset is synchronous and active-low.
- While RESET=0 on a CLOCK edge: all outputs 0, all channels IDLE, counters/accumulators 0.
- Channels are fully independent; shared inputs are AVG_EN and ERR_CLR only.
- Per-channel FSM states: IDLE, MEASURE.
  - IDLE: counter held at 0. LINE_END -> MEASURE with counter=1. FRAME_START alone: stays IDLE.
  - MEASURE: counter increments each cycle, saturating at 2^CNT_WIDTH-1.
- LINE_END in MEASURE:
  - Sample p = counter value; counter reloads to 1.
  - Taint flag cleared for the new line.
- Sample acceptance:
  - Accepted iff PERIOD_MIN <= p <= PERIOD_MAX and no PIXEL_ERROR since the previous LINE_END.
  - A PIXEL_ERROR coincident with the sampling LINE_END counts as inside the line.
  - Rejected sample: OUT_OF_RANGE[k] set next cycle; sample discarded; accumulator untouched.
- AVG_EN=0: accepted p written to LINE_PERIOD[k] and PERIOD_VALID[k]=1, both one cycle after LINE_END.
- AVG_EN=1:
  - Accepted p added to an accumulator of width CNT_WIDTH+AVG_LOG2; sample count incremented.
  - On the 2^AVG_LOG2-th sample: LINE_PERIOD[k] = (acc+p)>>AVG_LOG2 (truncate), PERIOD_VALID=1, acc and count cleared. Latency: 1 cycle after that LINE_END.
- AVG_EN toggled mid-run: accumulator and sample count cleared on the change; LINE_PERIOD held.
- FRAME_START in MEASURE:
  - Discards the partial line; accumulator, count and taint cleared; counter reloads to 1; state stays MEASURE.
  - PERIOD_VALID and LINE_PERIOD unchanged.
- FRAME_START and LINE_END in the same cycle: FRAME_START wins. No sample is taken; LINE_END is treated as the first edge (counter=1).
- Timeout: counter reaches TIMEOUT with no LINE_END.
  - Next cycle: state IDLE, PERIOD_VALID[k]=0, accumulator cleared.
  - LINE_PERIOD[k] keeps its last value, so config TX timing stays stable.
- ERR_CLR:
  - Clears all OUT_OF_RANGE bits next cycle.
  - If a rejection occurs in the same cycle, the set wins.
- LINE_PERIOD never changes except on an accepted update.

Decomposition:
- Shared package:
  - FSM state typedef (IDLE, MEASURE).
  - Default timing constants at 48 MHz: PERIOD_MIN, PERIOD_MAX, TIMEOUT.
  - Function computing accumulator width.
- One sub-module, line_period_ch: a single channel with FSM, counter, window check, accumulator and output registers.
  - Instantiated N_CH times in a generate loop.
  - The top level only slices buses and fans out AVG_EN and ERR_CLR.

Test Plan:
Bench parameters: N_CH=2, CNT_WIDTH=16, PERIOD_MIN=100, PERIOD_MAX=400, AVG_LOG2=2, TIMEOUT=800.
- Reset: RESET=0 for 3 cycles mid-measurement -> LINE_PERIOD=0, PERIOD_VALID=00, OUT_OF_RANGE=00 the cycle after the first low sample.
- AVG_EN=0, ch0 LINE_END every 200 cycles -> after 2nd pulse (+1 cycle) LINE_PERIOD[15:0]=200, PERIOD_VALID=01; ch1 remains 0.
- AVG_EN=1, ch1 periods 200,204,197,200 -> after 5th LINE_END (+1) LINE_PERIOD[31:16]=200 (801>>2); no update at pulses 2-4.
- ch0 period 50, then period 250 with a PIXEL_ERROR mid-line -> OUT_OF_RANGE[0]=1, LINE_PERIOD[15:0] unchanged; ERR_CLR pulse -> OUT_OF_RANGE[0]=0.
- ch0 tracking at 200, then LINE_END stopped for 800 cycles -> PERIOD_VALID[0]=0, LINE_PERIOD[15:0]=200 held; next two pulses 300 apart restore valid with 300 (AVG_EN=0).
- AVG_EN=1, two accepted samples then FRAME_START coincident with LINE_END -> no sample taken, accumulator cleared; four further 300-cycle lines -> LINE_PERIOD=300.
